regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/mips_pkg.sv | 18 +
 rtl/wb_slot.sv | 50 +++++
 rtl/regfile_wb_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the register-file writeback path.
//   DATA_W   : write-data width
//   REG_AW   : register index width
//   NUM_REGS : number of architectural registers
//   wb_req_t : one buffered writeback request {register index, data}
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [REG_AW-1:0] idx;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_slot.sv
// wb_slot
// One-entry writeback buffer with a full flag.
//   clk, rst  : clock, synchronous active-high reset
//   load_i    : capture reg_i/data_i and mark the slot full
//   clear_i   : mark the slot empty (ignored when load_i is also high)
//   reg_i     : destination register of the incoming request
//   data_i    : data of the incoming request
//   full_o    : slot holds a request
//   reg_o     : buffered destination register
//   data_o    : buffered data
module wb_slot #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [REG_AW-1:0] reg_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              full_o,
    output logic [REG_AW-1:0] reg_o,
    output logic [DATA_W-1:0] data_o
);

    logic              full_q;
    logic [REG_AW-1:0] reg_q;
    logic [DATA_W-1:0] data_q;

    // A load in the same cycle as a clear is a refill: the slot drains its
    // old entry to the write port and takes the new one at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            reg_q  <= '0;
            data_q <= '0;
        end else if (load_i) begin
            full_q <= 1'b1;
            reg_q  <= reg_i;
            data_q <= data_i;
        end else if (clear_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o = full_q;
    assign reg_o  = reg_q;
    assign data_o = data_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Merges ALU and load (MEM) writebacks onto the single register-bank write
// port. Each source owns a one-entry slot; the older full slot is granted
// each cycle, with MEM winning a tie, so same-register writes land in
// acceptance order.
//   clk, rst                         : clock, synchronous active-high reset
//   alu_valid/alu_ready/alu_reg/alu_data : ALU writeback handshake
//   mem_valid/mem_ready/mem_reg/mem_data : load writeback handshake
//   RegWrite, WriteRegister, WriteData   : register-bank write port
//   pending                          : per-register "write in flight" mask
module regfile_wb_arbiter #(
    parameter int DATA_W   = mips_pkg::DATA_W,
    parameter int NUM_REGS = mips_pkg::NUM_REGS,
    parameter int REG_AW   = mips_pkg::REG_AW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [REG_AW-1:0]   alu_reg,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [REG_AW-1:0]   mem_reg,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                RegWrite,
    output logic [REG_AW-1:0]   WriteRegister,
    output logic [DATA_W-1:0]   WriteData,
    output logic [NUM_REGS-1:0] pending
);

    logic              aluFull, memFull;
    logic [REG_AW-1:0] aluSlotReg, memSlotReg;
    logic [DATA_W-1:0] aluSlotData, memSlotData;
    logic              aluGrant, memGrant, anyGrant;
    logic              aluLoad, memLoad;
    logic              aluRemain, memRemain;
    logic              aluAge_q, aluAge_d;
    logic              memAge_q, memAge_d;
    logic [REG_AW-1:0] grantReg;
    logic [DATA_W-1:0] grantData;
    logic              RegWrite_q;
    logic [REG_AW-1:0] WriteRegister_q;
    logic [DATA_W-1:0] WriteData_q;

    wb_slot #(.DATA_W(DATA_W), .REG_AW(REG_AW)) uAluSlot (
        .clk     (clk),
        .rst     (rst),
        .load_i  (aluLoad),
        .clear_i (aluGrant),
        .reg_i   (alu_reg),
        .data_i  (alu_data),
        .full_o  (aluFull),
        .reg_o   (aluSlotReg),
        .data_o  (aluSlotData)
    );

    wb_slot #(.DATA_W(DATA_W), .REG_AW(REG_AW)) uMemSlot (
        .clk     (clk),
        .rst     (rst),
        .load_i  (memLoad),
        .clear_i (memGrant),
        .reg_i   (mem_reg),
        .data_i  (mem_data),
        .full_o  (memFull),
        .reg_o   (memSlotReg),
        .data_o  (memSlotData)
    );

    // Age bit set means "this slot is the oldest entry". ALU only wins when
    // it is strictly older; equal age (same-edge load) falls through to MEM.
    // Ready is a function of slot state only, so valid never loops back.
    always_comb begin
        aluGrant  = aluFull && (!memFull || (aluAge_q && !memAge_q));
        memGrant  = memFull && !aluGrant;
        anyGrant  = aluGrant || memGrant;
        alu_ready = !aluFull || aluGrant;
        mem_ready = !memFull || memGrant;
        aluLoad   = alu_valid && alu_ready;
        memLoad   = mem_valid && mem_ready;
        aluRemain = aluFull && !aluGrant;
        memRemain = memFull && !memGrant;
        grantReg  = aluGrant ? aluSlotReg  : memSlotReg;
        grantData = aluGrant ? aluSlotData : memSlotData;
    end

    // A freshly loaded slot is younger only if the other slot stays full
    // across the edge. A slot that survives an edge is always the oldest,
    // since one grant per cycle means the other slot was drained or empty.
    always_comb begin
        aluAge_d = 1'b0;
        memAge_d = 1'b0;
        if (aluLoad) begin
            aluAge_d = !memRemain;
        end else if (aluRemain) begin
            aluAge_d = 1'b1;
        end
        if (memLoad) begin
            memAge_d = !aluRemain;
        end else if (memRemain) begin
            memAge_d = 1'b1;
        end
    end

    // Write port register: register 0 grants are consumed but never raise
    // RegWrite. Index/data only move on a grant so they hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            aluAge_q        <= 1'b0;
            memAge_q        <= 1'b0;
            RegWrite_q      <= 1'b0;
            WriteRegister_q <= '0;
            WriteData_q     <= '0;
        end else begin
            aluAge_q   <= aluAge_d;
            memAge_q   <= memAge_d;
            RegWrite_q <= anyGrant && (grantReg != '0);
            if (anyGrant) begin
                WriteRegister_q <= grantReg;
                WriteData_q     <= grantData;
            end
        end
    end

    assign RegWrite      = RegWrite_q;
    assign WriteRegister = WriteRegister_q;
    assign WriteData     = WriteData_q;

    // Register 0 is hardwired, so its bit is never reported as pending.
    always_comb begin
        pending = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            pending[i] = (aluFull && (aluSlotReg == REG_AW'(i))) ||
                         (memFull && (memSlotReg == REG_AW'(i))) ||
                         (RegWrite_q && (WriteRegister_q == REG_AW'(i)));
        end
    end

endmodule
